// File: rtl/mem_port_arbiter.sv
// Shares one memory bus among NumPorts requesters, one atomic transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mem_port_arbiter #(
   parameter int NumPorts     = 2,
   parameter int AddrBusWidth = 32,
   parameter int DataWidth    = 32
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   input  logic [NumPorts-1:0][AddrBusWidth-1:0]  i_port_addr,
   input  logic [NumPorts-1:0][DataWidth-1:0]     i_port_w_data,
   input  logic [NumPorts-1:0]                    i_port_re,
   input  logic [NumPorts-1:0]                    i_port_we,
   output logic [NumPorts-1:0]                    o_port_ready,
   output logic [NumPorts-1:0][DataWidth-1:0]     o_port_r_data,
   output logic [NumPorts-1:0]                    o_port_r_data_valid,
   output logic [AddrBusWidth-1:0]                o_mem_addr,
   output logic [DataWidth-1:0]                   o_mem_w_data,
   output logic                                   o_mem_re,
   output logic                                   o_mem_we,
   input  logic                                   i_mem_ready,
   input  logic [DataWidth-1:0]                   i_mem_r_data,
   input  logic                                   i_mem_r_data_valid
);
   localparam int GW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                  r_state, w_next;
   logic [GW-1:0]           r_gnt, w_gnt;
   logic                    r_op;
   logic [AddrBusWidth-1:0] r_addr;
   logic [DataWidth-1:0]    r_wdata, r_rdata;
   logic [NumPorts-1:0]     w_pend;
   logic                    w_any, w_accept, w_cap;

   assign w_pend   = i_port_re | i_port_we;
   assign w_any    = |w_pend;
   assign w_accept = (r_state == IDLE) && w_any;
   assign w_cap    = ((r_state == ISSUE) || (r_state == WAIT)) && !r_op && i_mem_r_data_valid;

`ifdef MEM_ARB_RR_EN
   logic [GW-1:0] r_last;

   // Scan from farthest to nearest so the port right after r_last wins.
   always_comb begin
      int idx;
      idx   = 0;
      w_gnt = '0;
      for (int k = NumPorts; k >= 1; k--) begin
         idx = (int'(r_last) + k) % NumPorts;
         if (w_pend[idx]) w_gnt = GW'(idx);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)         r_last <= GW'(NumPorts - 1);
      else if (w_accept) r_last <= w_gnt;
   end
`else
   always_comb begin
      w_gnt = '0;
      for (int i = NumPorts - 1; i >= 0; i--) begin
         if (w_pend[i]) w_gnt = GW'(i);
      end
   end
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (w_any) w_next = ISSUE;
         ISSUE: if (i_mem_ready) w_next = (r_op || i_mem_r_data_valid) ? RESP : WAIT;
         WAIT:  if (i_mem_r_data_valid) w_next = RESP;
         RESP:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_op    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         // A write wins when re and we are both high.
         if (w_accept) begin
            r_gnt   <= w_gnt;
            r_addr  <= i_port_addr[w_gnt];
            r_wdata <= i_port_w_data[w_gnt];
            r_op    <= i_port_we[w_gnt];
         end
         if (w_cap) r_rdata <= i_mem_r_data;
      end
   end

   assign o_mem_addr    = r_addr;
   assign o_mem_w_data  = r_wdata;
   assign o_mem_we      = (r_state == ISSUE) && r_op;
   assign o_mem_re      = (r_state == ISSUE) && !r_op;
   assign o_port_r_data = {NumPorts{r_rdata}};

   always_comb begin
      o_port_ready        = '0;
      o_port_r_data_valid = '0;
      if (r_state == RESP) begin
         o_port_ready[r_gnt]        = 1'b1;
         o_port_r_data_valid[r_gnt] = !r_op;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with NumPorts=2.
module tb_mem_port_arbiter;
   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NP-1:0][AW-1:0] port_addr;
   logic [NP-1:0][DW-1:0] port_w_data;
   logic [NP-1:0]        port_re, port_we;
   logic [NP-1:0]        port_ready, port_r_data_valid;
   logic [NP-1:0][DW-1:0] port_r_data;
   logic [AW-1:0]        mem_addr;
   logic [DW-1:0]        mem_w_data, mem_r_data;
   logic                 mem_re, mem_we, mem_ready, mem_r_data_valid;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(.NumPorts(NP), .AddrBusWidth(AW), .DataWidth(DW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_port_addr(port_addr), .i_port_w_data(port_w_data),
      .i_port_re(port_re), .i_port_we(port_we),
      .o_port_ready(port_ready), .o_port_r_data(port_r_data),
      .o_port_r_data_valid(port_r_data_valid),
      .o_mem_addr(mem_addr), .o_mem_w_data(mem_w_data),
      .o_mem_re(mem_re), .o_mem_we(mem_we),
      .i_mem_ready(mem_ready), .i_mem_r_data(mem_r_data),
      .i_mem_r_data_valid(mem_r_data_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_ports();
      port_addr   = '0;
      port_w_data = '0;
      port_re     = '0;
      port_we     = '0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_rdy"}, 64'(port_ready), 64'h0);
      chk({tag, "_rv"},  64'(port_r_data_valid), 64'h0);
   endtask

   initial begin
      int got;
      int seen;
      int exp_order[4];
      rst = 1'b1;
      clr_ports();
      mem_ready = 1'b0; mem_r_data = '0; mem_r_data_valid = 1'b0;
      #2;
      chk("rst_rdy", 64'(port_ready), 0);
      chk("rst_rv", 64'(port_r_data_valid), 0);
      chk("rst_mre", 64'(mem_re), 0);
      chk("rst_mwe", 64'(mem_we), 0);
      chk("rst_addr", 64'(mem_addr), 0);
      chk("rst_wdat", 64'(mem_w_data), 0);
      chk("rst_rdat", 64'(port_r_data[0]), 0);
      tick();
      rst = 1'b0;
      tick();

      // Single write from port 1, memory always ready.
      mem_ready = 1'b1;
      port_we[1] = 1'b1; port_addr[1] = 32'h100; port_w_data[1] = 32'hDEADBEEF;
      chk("w_c0_mwe", 64'(mem_we), 0);
      tick();
      chk("w_c1_mwe", 64'(mem_we), 1);
      chk("w_c1_mre", 64'(mem_re), 0);
      chk("w_c1_addr", 64'(mem_addr), 64'h100);
      chk("w_c1_wdat", 64'(mem_w_data), 64'hDEADBEEF);
      chk_quiet("w_c1");
      tick();
      chk("w_c2_rdy", 64'(port_ready), 64'b10);
      chk("w_c2_rv", 64'(port_r_data_valid), 0);
      chk("w_c2_mwe", 64'(mem_we), 0);
      clr_ports();
      tick();
      chk_quiet("w_c3");

      // Read from port 0 with two stall cycles and late data.
      mem_ready = 1'b0;
      port_re[0] = 1'b1; port_addr[0] = 32'h40;
      tick();
      chk("r_c1_mre", 64'(mem_re), 1);
      chk("r_c1_addr", 64'(mem_addr), 64'h40);
      tick();
      chk("r_c2_mre", 64'(mem_re), 1);
      chk("r_c2_addr", 64'(mem_addr), 64'h40);
      tick();
      chk("r_c3_mre", 64'(mem_re), 1);
      chk("r_c3_addr", 64'(mem_addr), 64'h40);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("r_wait_mre", 64'(mem_re), 0);
      chk_quiet("r_wait");
      tick();
      tick();
      mem_r_data = 32'h12345678; mem_r_data_valid = 1'b1;
      chk_quiet("r_c6");
      tick();
      mem_r_data_valid = 1'b0;
      chk("r_rdy", 64'(port_ready), 64'b01);
      chk("r_rv", 64'(port_r_data_valid), 64'b01);
      chk("r_data", 64'(port_r_data[0]), 64'h12345678);
      clr_ports();
      tick();
      chk_quiet("r_after");

      // Read accepted and answered in the ISSUE cycle: WAIT is skipped.
      port_re[0] = 1'b1; port_addr[0] = 32'h80;
      tick();
      chk("s_c1_mre", 64'(mem_re), 1);
      mem_ready = 1'b1; mem_r_data = 32'hCAFEF00D; mem_r_data_valid = 1'b1;
      tick();
      mem_r_data_valid = 1'b0;
      chk("s_rdy", 64'(port_ready), 64'b01);
      chk("s_rv", 64'(port_r_data_valid), 64'b01);
      chk("s_data", 64'(port_r_data[0]), 64'hCAFEF00D);
      clr_ports();
      tick();

      // re and we together on port 1 behave as a write.
      port_re[1] = 1'b1; port_we[1] = 1'b1; port_addr[1] = 32'h200; port_w_data[1] = 32'h55AA;
      tick();
      chk("rw_mwe", 64'(mem_we), 1);
      chk("rw_mre", 64'(mem_re), 0);
      tick();
      chk("rw_rdy", 64'(port_ready), 64'b10);
      chk("rw_rv", 64'(port_r_data_valid), 0);
      clr_ports();
      tick();

      // Contention: both ports keep requesting writes.
`ifdef MEM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      port_we = 2'b11; port_addr[0] = 32'h10; port_addr[1] = 32'h20;
      for (int t = 0; t < 5; t++) begin
         seen = 0;
         got  = -1;
         for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (port_ready != 0) begin
               seen = 1;
               got  = port_ready[1] ? 1 : 0;
            end
         end
         if (!seen) chk("cont_timeout", 64'd0, 64'd1);
         else if (t < 4) chk($sformatf("cont_g%0d", t), 64'(got), 64'(exp_order[t]));
         else chk("cont_after_drop", 64'(got), 64'd1);
         if (t == 3) port_we[0] = 1'b0;
         if (t == 4) clr_ports();
      end
      tick();

      // Reset asserted while waiting for read data.
      port_re[0] = 1'b1; port_addr[0] = 32'h300;
      tick();
      tick();
      mem_ready = 1'b0;
      chk("rm_wait_mre", 64'(mem_re), 0);
      rst = 1'b1;
      #1;
      chk("rm_rdy", 64'(port_ready), 0);
      chk("rm_rv", 64'(port_r_data_valid), 0);
      chk("rm_mre", 64'(mem_re), 0);
      chk("rm_mwe", 64'(mem_we), 0);
      chk("rm_addr", 64'(mem_addr), 0);
      chk("rm_rdat", 64'(port_r_data[0]), 0);
      clr_ports();
      mem_r_data = 32'h0BAD0BAD; mem_r_data_valid = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk_quiet("rm_stale1");
      tick();
      chk_quiet("rm_stale2");
      chk("rm_stale_dat", 64'(port_r_data[1]), 0);
      mem_r_data_valid = 1'b0; mem_ready = 1'b1;
      port_we[1] = 1'b1; port_addr[1] = 32'h400; port_w_data[1] = 32'h77;
      tick();
      chk("rm_new_mwe", 64'(mem_we), 1);
      chk("rm_new_addr", 64'(mem_addr), 64'h400);
      tick();
      chk("rm_new_rdy", 64'(port_ready), 64'b10);
      chk("rm_new_rv", 64'(port_r_data_valid), 0);
      clr_ports();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one memory bus among `NumPorts` cache-side requesters. It grants one request at a time, drives the memory interface, and returns the write completion or read data to the granted port only. It sits between the per-port cache front ends and the external memory controller. It holds the grant from acceptance to response, so each transaction is atomic.

## Interface
Parameters:
- `NumPorts`, 2: number of requesters; must be at least 2.
- `AddrBusWidth`, 32: address width.
- `DataWidth`, 32: data width, identical on the port side and the memory side.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `port_addr[NumPorts]`  in  AddrBusWidth  request address; held stable while the request is pending.
- `port_w_data[NumPorts]`  in  DataWidth  write data; held stable while the request is pending.
- `port_re[NumPorts]`  in  1  read request.
- `port_we[NumPorts]`  in  1  write request.
- `port_ready[NumPorts]`  out  1  one-cycle completion pulse to the granted port.
- `port_r_data[NumPorts]`  out  DataWidth  read data; valid only when `port_r_data_valid` is high.
- `port_r_data_valid[NumPorts]`  out  1  one-cycle read-data pulse.
- `mem_addr`  out  AddrBusWidth  memory address.
- `mem_w_data`  out  DataWidth  memory write data.
- `mem_re`  out  1  memory read strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_ready`  in  1  memory accepts the strobe in the current cycle.
- `mem_r_data`  in  DataWidth  memory read data.
- `mem_r_data_valid`  in  1  `mem_r_data` is valid this cycle.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - A port is pending when `port_re | port_we` is high for that port.
  - If any port is pending, select the winner `g`.
  - Latch `g`, `port_addr[g]`, `port_w_data[g]`, and `op = port_we[g]`.
  - If `re` and `we` are both high, the transaction is a write and `re` is ignored.
  - Update `last_grant <= g` and go to ISSUE.
- **ISSUE**
  - Drive `mem_addr` and `mem_w_data` from the latches.
  - Drive `mem_we = op` and `mem_re = ~op`.
  - Hold these until `mem_ready` is sampled high.
  - On `mem_ready`, a write goes to RESP.
  - On `mem_ready`, a read goes to RESP if `mem_r_data_valid` is also high this cycle, otherwise to WAIT.
  - Read data is captured whenever `mem_r_data_valid` is high.
- **WAIT**
  - Strobes are low.
  - On `mem_r_data_valid`, capture `mem_r_data` and go to RESP.
- **RESP**
  - `port_ready[g] = 1`.
  - For a read, also `port_r_data_valid[g] = 1`.
  - Go to IDLE the next cycle.
- All `port_r_data[i]` are driven from the capture register. Only port `g` sees the valid pulse.
- A requester must drop `re`/`we` in the cycle after its `port_ready`. A request still held then is arbitrated as a new transaction.
- Ungranted pending requests wait. They receive no signal until they are granted.
- `mem_r_data_valid` outside ISSUE and WAIT is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - All `port_ready`, `port_r_data_valid`, `mem_re`, and `mem_we` are 0.
  - `mem_addr`, `mem_w_data`, and the capture register are 0.
  - `last_grant = NumPorts-1`, so port 0 has first priority.
- Reset mid-transaction:
  - The transaction is abandoned immediately and no response is issued.
  - The memory side must be reset together with this block.
- Write latency: request seen at cycle 0 → strobe at cycle 1. With `mem_ready` at cycle 1, `port_ready` is at cycle 2. Each stall cycle of `mem_ready` adds one cycle.
- Read latency: with `mem_r_data_valid` at cycle k (k ≥ 1), `port_r_data_valid` and `port_ready` are at cycle k+1.
- Throughput: at most one transaction per 3 cycles (IDLE, ISSUE, RESP).
- Strobes and address are stable from ISSUE entry until `mem_ready`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - Priority order is `last_grant+1, last_grant+2, …`, wrapping modulo `NumPorts`.
  - `last_grant` wraps from `NumPorts-1` to 0.
- `MEM_ARB_RR_EN` undefined: fixed priority.
  - The lowest-index pending port always wins.
  - `last_grant` is unused and may be optimised away.

## Test plan
- Single write:
  - Stimulus: port 1 write, addr 0x100, data 0xDEADBEEF, `mem_ready` tied to 1.
  - Required: `mem_we=1` with addr 0x100 at cycle 1; `port_ready[1]` at cycle 2 only; no `port_r_data_valid`.
- Read with latency:
  - Stimulus: port 0 read, addr 0x40. `mem_ready` is held low for 2 cycles then goes high. Data 0x12345678 is valid 3 cycles after acceptance.
  - Required: address is held throughout the stall; `port_r_data_valid[0]` and `port_ready[0]` pulse together with 0x12345678; port 1 sees nothing.
- Contention, `NumPorts=2`, both ports continuously requesting 4 transactions:
  - With `MEM_ARB_RR_EN`, the grant order is 0, 1, 0, 1.
  - Without it, port 0 is served back-to-back until it drops its request.
- Same-cycle accept and data:
  - Stimulus: read where `mem_ready` and `mem_r_data_valid` are both high in the ISSUE cycle.
  - Required: RESP follows immediately and the WAIT state is skipped.
- Both `re` and `we` high on port 1:
  - Required: only `mem_we` is asserted; `port_ready[1]` pulses; `port_r_data_valid[1]` stays 0.
- Reset mid-transaction:
  - Stimulus: assert `rst` during WAIT.
  - Required: all outputs are 0 asynchronously. After `rst` is released, a new request is served normally and the stale `mem_r_data_valid` is ignored.
